// File: rtl/vram_dp_if.sv
// VRAM port bundle: CPU byte-lane access, display read channel and fill-screen control.
// The vram_dp memory is the slave; the CPU/display/controller side is the master.
interface vram_dp_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4800,
   parameter int ADDR_W = 14
);
   logic                       cpu_we;
   logic [DATA_W/8-1:0]        cpu_be;
   logic [ADDR_W-1:0]          cpu_a;
   logic [DATA_W-1:0]          cpu_wd;
   logic [DATA_W-1:0]          cpu_rd;
   logic                       vga_re;
   logic [$clog2(DEPTH)-1:0]   vga_a;
   logic [DATA_W-1:0]          vga_rd;
   logic                       vga_valid;
   logic                       clr_start;
   logic [DATA_W-1:0]          clr_value;
   logic                       clr_busy;
   logic                       clr_done;

   modport master (
      output cpu_we, cpu_be, cpu_a, cpu_wd, vga_re, vga_a, clr_start, clr_value,
      input  cpu_rd, vga_rd, vga_valid, clr_busy, clr_done
   );

   modport slave (
      input  cpu_we, cpu_be, cpu_a, cpu_wd, vga_re, vga_a, clr_start, clr_value,
      output cpu_rd, vga_rd, vga_valid, clr_busy, clr_done
   );
endinterface

// File: rtl/vram_dp.sv
// Dual-port text-mode VRAM: CPU byte-lane port, display read port, hardware fill-screen.
// Optional VRAM_TRACE_EN: simulation trace of accepted CPU writes and fill start/finish.
module vram_dp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4800,
   parameter int ADDR_W = 14
) (
   input  logic       clk,
   input  logic       rst_n,
   vram_dp_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = ADDR_W - 2;
   localparam int IW = ((CW > AW) ? CW : AW) + 1;
   localparam int NB = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_DONE
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   logic [AW-1:0]     ptr;
   logic [DATA_W-1:0] fill_val;
   logic              clr_busy_q;
   logic              clr_done_q;

   logic [DATA_W-1:0] cpu_rd_p0;
   logic [DATA_W-1:0] vga_rd_p0;
   logic              vld_p0;

   // Word index is widened so the range test works whether the CPU window is
   // narrower or wider than the array.
   logic [IW-1:0]     cpu_idx;
   logic [AW-1:0]     cpu_word;
   logic              cpu_in_rng;
   logic              vga_in_rng;
   logic              clr_go;
   logic              clr_wr;
   logic              cpu_wr_ok;

   assign cpu_idx    = IW'(bus.cpu_a[ADDR_W-1:2]);
   assign cpu_word   = cpu_idx[AW-1:0];
   assign cpu_in_rng = (cpu_idx < IW'(DEPTH));
   assign vga_in_rng = ({1'b0, bus.vga_a} < (AW+1)'(DEPTH));

   assign clr_go     = (state == S_IDLE) && bus.clr_start;
   assign clr_wr     = (state == S_CLEAR);
   // A fill request in the same cycle wins over the CPU write.
   assign cpu_wr_ok  = rst_n && (state == S_IDLE) && !bus.clr_start &&
                       bus.cpu_we && cpu_in_rng;

   // Fill-screen FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               clr_done_q <= 1'b0;
               if (bus.clr_start) begin
                  state      <= S_CLEAR;
                  ptr        <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (ptr == AW'(DEPTH - 1)) begin
                  state      <= S_DONE;
                  clr_done_q <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b0;
            end
            default: begin
               state      <= S_IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Memory write port: fill engine or CPU byte lanes (array is never reset)
   always_ff @(posedge clk) begin
      if (clr_go)
         fill_val <= bus.clr_value;
      if (clr_wr) begin
         mem[ptr] <= fill_val;
      end else if (cpu_wr_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.cpu_be[i])
               mem[cpu_word][8*i +: 8] <= bus.cpu_wd[8*i +: 8];
         end
      end
   end

   // Read stage p0: both ports see pre-write contents of this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rd_p0 <= '0;
         vga_rd_p0 <= '0;
         vld_p0    <= 1'b0;
      end else begin
         cpu_rd_p0 <= cpu_in_rng ? mem[cpu_word] : '0;
         vld_p0    <= bus.vga_re;
         if (bus.vga_re)
            vga_rd_p0 <= vga_in_rng ? mem[bus.vga_a] : '0;
      end
   end

   assign bus.cpu_rd    = cpu_rd_p0;
   assign bus.vga_rd    = vga_rd_p0;
   assign bus.vga_valid = vld_p0;
   assign bus.clr_busy  = clr_busy_q;
   assign bus.clr_done  = clr_done_q;

`ifdef VRAM_TRACE_EN
   always_ff @(posedge clk) begin
      if (cpu_wr_ok)
         $display("VRAM wr addr=%h data=%h char='%c' colour=%h",
                  bus.cpu_a, bus.cpu_wd, bus.cpu_wd[7:0], bus.cpu_wd[DATA_W-1:8]);
      if (clr_go)
         $display("VRAM clear start value=%h", bus.clr_value);
      if (rst_n && state == S_DONE)
         $display("VRAM clear done value=%h", fill_val);
   end
`endif

endmodule
